// File: rtl/vga_sync_rx_pkg.sv
// Shared SVGA 800x600@60 timing constants and receiver FSM encoding.
// The generator and the receiver both derive their timing from here.
package vga_sync_rx_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FRONT + SVGA_H_SYNC + SVGA_H_BACK;

  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FRONT + SVGA_V_SYNC + SVGA_V_BACK;

  // Active video starts after sync pulse plus back porch.
  localparam int SVGA_H_OFS = SVGA_H_SYNC + SVGA_H_BACK;
  localparam int SVGA_V_OFS = SVGA_V_SYNC + SVGA_V_BACK;

  localparam int RX_LOCK_LINES = 4;
  localparam int RX_CW         = 11;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_sync_rx_sync_edge_det.sv
// Two-flop synchronizer for an active-low sync input plus a delay flop
// producing a single-cycle falling-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic w_rst_n,
  input  logic sync_in,
  output logic fall
);

  logic meta;
  logic stable;
  logic prev;

  // Stages idle high so a sync held low through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      meta   <= 1'b1;
      stable <= 1'b1;
      prev   <= 1'b1;
    end else begin
      meta   <= sync_in;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign fall = prev & ~stable;

endmodule

// File: rtl/vga_sync_rx.sv
// SVGA sync receiver: measures line/frame periods from incoming hsync/vsync,
// locks to exact expected timing and regenerates pixel coordinates.
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int H_ACTIVE   = SVGA_H_ACTIVE,
  parameter int V_ACTIVE   = SVGA_V_ACTIVE,
  parameter int H_TOTAL    = SVGA_H_TOTAL,
  parameter int V_TOTAL    = SVGA_V_TOTAL,
  parameter int H_OFS      = SVGA_H_OFS,
  parameter int V_OFS      = SVGA_V_OFS,
  parameter int LOCK_LINES = RX_LOCK_LINES,
  parameter int CW         = RX_CW
) (
  input  logic          clk,
  input  logic          w_rst_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          active,
  output logic          frame_start,
  output logic          locked,
  output logic [CW-1:0] h_period
);

  localparam int CNT_MAX_I = (1 << CW) - 1;
  // With the default width the counter saturates before twice a line period,
  // so the missing-hsync timeout fires at saturation in that case.
  localparam int TIMEOUT_I = (2 * H_TOTAL > CNT_MAX_I) ? CNT_MAX_I : 2 * H_TOTAL;
  localparam int MW        = $clog2(LOCK_LINES + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_MAX_I);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_TIMEOUT = CW'(TIMEOUT_I);
  localparam logic [CW-1:0] H_LO      = CW'(H_OFS);
  localparam logic [CW-1:0] H_HI      = CW'(H_OFS + H_ACTIVE);
  localparam logic [CW-1:0] V_LO      = CW'(V_OFS);
  localparam logic [CW-1:0] V_HI      = CW'(V_OFS + V_ACTIVE);
  localparam logic [CW-1:0] V_TOT     = CW'(V_TOTAL);
  localparam logic [MW-1:0] LOCK_M    = MW'(LOCK_LINES);
  localparam logic [MW-1:0] M_ONE     = MW'(1);

  logic          hs_fall;
  logic          vs_fall;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] line_cnt;
  logic [CW-1:0] lines_seen;
  logic          pend_v;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;
  rx_state_t     state;
  rx_state_t     state_nxt;
  logic          win;

  sync_edge_det u_hs_edge (
    .clk     (clk),
    .w_rst_n (w_rst_n),
    .sync_in (hsync_in),
    .fall    (hs_fall)
  );

  sync_edge_det u_vs_edge (
    .clk     (clk),
    .w_rst_n (w_rst_n),
    .sync_in (vsync_in),
    .fall    (vs_fall)
  );

  // Lines in the frame including a line start coinciding with this vsync fall,
  // so vsync aligned to hsync and vsync mid-line both count V_TOTAL.
  always_comb begin
    lines_seen = line_cnt;
    if (hs_fall && line_cnt != CNT_MAX) begin
      lines_seen = line_cnt + ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    case (state)
      SEARCH: begin
        if (hs_fall) begin
          state_nxt = TRACK;
          match_nxt = '0;
        end
      end
      TRACK: begin
        if (hs_fall) begin
          if (hcnt == H_LAST) begin
            match_nxt = (match_cnt >= LOCK_M) ? match_cnt : match_cnt + M_ONE;
          end else begin
            match_nxt = '0;
          end
        end
        if (vs_fall && match_cnt >= LOCK_M) begin
          state_nxt = LOCKED;
        end else if (hcnt >= H_TIMEOUT) begin
          state_nxt = SEARCH;
        end
      end
      LOCKED: begin
        if ((hs_fall && hcnt != H_LAST) ||
            (vs_fall && lines_seen != V_TOT) ||
            (hcnt >= H_TIMEOUT)) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_cnt  <= '0;
      pend_v    <= 1'b0;
      h_period  <= '0;
      match_cnt <= '0;
      state     <= SEARCH;
    end else begin
      hcnt <= hs_fall ? '0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + ONE);
      if (hs_fall) begin
        h_period <= (hcnt == CNT_MAX) ? CNT_MAX : hcnt + ONE;
      end
      if (vs_fall) begin
        line_cnt <= '0;
      end else if (hs_fall && line_cnt != CNT_MAX) begin
        line_cnt <= line_cnt + ONE;
      end
      // A vsync fall arms a vertical restart that takes effect on the next line start.
      if (hs_fall) begin
        if (pend_v || vs_fall) begin
          vcnt <= '0;
        end else if (vcnt != CNT_MAX) begin
          vcnt <= vcnt + ONE;
        end
        pend_v <= 1'b0;
      end else if (vs_fall) begin
        pend_v <= 1'b1;
      end
      match_cnt <= match_nxt;
      state     <= state_nxt;
    end
  end

  assign win = (state_nxt == LOCKED) &&
               (hcnt >= H_LO) && (hcnt < H_HI) &&
               (vcnt >= V_LO) && (vcnt < V_HI);

  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      active      <= 1'b0;
      locked      <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      active      <= win;
      locked      <= (state_nxt == LOCKED);
      pos_x       <= win ? hcnt - H_LO : '0;
      pos_y       <= win ? vcnt - V_LO : '0;
      frame_start <= win && (hcnt == H_LO) && (vcnt == V_LO);
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down timing so that many
// frames fit in a short run; expected values follow from that timing.
module tb_vga_sync_rx;

  localparam int H_ACT  = 8;
  localparam int H_SYNC = 4;
  localparam int H_OFS  = 6;
  localparam int H_TOT  = 20;
  localparam int V_ACT  = 5;
  localparam int V_SYNC = 2;
  localparam int V_OFS  = 3;
  localparam int V_TOT  = 10;
  localparam int LOCK   = 4;
  localparam int CW     = 11;

  logic          clk = 1'b0;
  logic          w_rst_n;
  logic          hsync_in;
  logic          vsync_in;
  logic [CW-1:0] pos_x;
  logic [CW-1:0] pos_y;
  logic          active;
  logic          frame_start;
  logic          locked;
  logic [CW-1:0] h_period;

  int n_checks = 0;
  int n_fail   = 0;

  int active_cnt = 0, fs_cnt = 0, gap_cnt = 0, run_err = 0, zero_err = 0;
  int max_x = 0, max_y = 0, run_len = 0, prev_x = 0, fs_x = -1, fs_y = -1;
  logic prev_active = 1'b0;

  int s_act, s_fs, s_gap, s_run, s_zero;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .H_TOTAL    (H_TOT),
    .V_TOTAL    (V_TOT),
    .H_OFS      (H_OFS),
    .V_OFS      (V_OFS),
    .LOCK_LINES (LOCK),
    .CW         (CW)
  ) dut (
    .clk         (clk),
    .w_rst_n     (w_rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .h_period    (h_period)
  );

  // Running statistics on the regenerated raster, sampled mid-cycle.
  always @(negedge clk) begin
    if (active) begin
      active_cnt++;
      if (prev_active ? (int'(pos_x) != prev_x + 1) : (pos_x != '0)) gap_cnt++;
      run_len++;
      if (int'(pos_x) > max_x) max_x = int'(pos_x);
      if (int'(pos_y) > max_y) max_y = int'(pos_y);
    end else begin
      if (prev_active && run_len != H_ACT) run_err++;
      run_len = 0;
      if (pos_x != '0 || pos_y != '0 || frame_start) zero_err++;
    end
    if (frame_start) begin
      fs_cnt++;
      fs_x = int'(pos_x);
      fs_y = int'(pos_y);
    end
    prev_active = active;
    prev_x      = int'(pos_x);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives pin columns start_h..len-1 of one line; hsync low for the first H_SYNC clocks.
  task automatic applyStimulus(input int start_h, input int len, input logic vs_lvl);
    for (int h = start_h; h < len; h++) begin
      hsync_in = (h < H_SYNC) ? 1'b0 : 1'b1;
      vsync_in = vs_lvl;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic vs_level(input int v);
    return (v < V_SYNC) ? 1'b0 : 1'b1;
  endfunction

  task automatic send_lines(input int first, input int last);
    for (int v = first; v <= last; v++) applyStimulus(0, H_TOT, vs_level(v));
  endtask

  task automatic idle(input int n);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snapshot();
    s_act  = active_cnt;
    s_fs   = fs_cnt;
    s_gap  = gap_cnt;
    s_run  = run_err;
    s_zero = zero_err;
  endtask

  task automatic check_clean_frame(input string tag);
    checkOutput({tag, "_active_cycles"}, active_cnt - s_act, H_ACT * V_ACT);
    checkOutput({tag, "_frame_starts"}, fs_cnt - s_fs, 1);
    checkOutput({tag, "_x_gaps"}, gap_cnt - s_gap, 0);
    checkOutput({tag, "_bad_runs"}, run_err - s_run, 0);
    checkOutput({tag, "_idle_nonzero"}, zero_err - s_zero, 0);
    checkOutput({tag, "_h_period"}, int'(h_period), H_TOT);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    w_rst_n  = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_pos_x", int'(pos_x), 0);
    checkOutput("reset_pos_y", int'(pos_y), 0);
    checkOutput("reset_frame_start", frame_start, 0);
    checkOutput("reset_h_period", int'(h_period), 0);
    w_rst_n = 1'b1;

    // Frame 1 trains the line matcher; lock comes on the next vsync fall.
    send_lines(0, V_TOT - 1);
    checkOutput("no_lock_first_frame", locked, 0);
    snapshot();
    applyStimulus(0, H_TOT, 1'b0);
    checkOutput("lock_at_vsync", locked, 1);
    send_lines(1, V_TOT - 1);
    check_clean_frame("frame2");
    checkOutput("frame_start_x", fs_x, 0);
    checkOutput("frame_start_y", fs_y, 0);
    checkOutput("max_pos_x", max_x, H_ACT - 1);
    checkOutput("max_pos_y", max_y, V_ACT - 1);

    // Short line: the early hsync fall is acted on three clocks after the pin edge.
    send_lines(0, 4);
    applyStimulus(0, 16, 1'b1);
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("lock_held_before_edge", locked, 1);
    @(posedge clk); #1;
    checkOutput("lock_drop_short_line", locked, 0);
    checkOutput("h_period_short", int'(h_period), 16);
    applyStimulus(3, H_TOT, 1'b1);
    send_lines(7, V_TOT - 1);
    send_lines(0, V_TOT - 1);
    checkOutput("no_early_relock", locked, 0);
    applyStimulus(0, H_TOT, 1'b0);
    checkOutput("relock_after_short_line", locked, 1);

    // Nine-line frame breaks lock on the following vsync fall.
    send_lines(1, V_TOT - 2);
    snapshot();
    applyStimulus(0, H_TOT, 1'b0);
    checkOutput("drop_on_short_frame", locked, 0);
    send_lines(1, V_TOT - 1);
    checkOutput("no_active_while_unlocked", active_cnt - s_act, 0);
    send_lines(0, V_TOT - 1);
    checkOutput("relock_after_short_frame", locked, 1);

    // Missing hsync: lock holds below twice the line period, drops past it.
    idle(15);
    checkOutput("lock_before_timeout", locked, 1);
    idle(30);
    checkOutput("timeout_unlock", locked, 0);
    checkOutput("timeout_pos_x", int'(pos_x), 0);
    checkOutput("timeout_pos_y", int'(pos_y), 0);

    // Reacquire, then reset mid-line on an active pixel.
    send_lines(0, V_TOT - 1);
    send_lines(0, 3);
    applyStimulus(0, 10, 1'b1);
    checkOutput("pre_reset_active", active, 1);
    checkOutput("pre_reset_pos_x", int'(pos_x), 0);
    checkOutput("pre_reset_pos_y", int'(pos_y), 1);
    w_rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_pos_x", int'(pos_x), 0);
    checkOutput("rst_pos_y", int'(pos_y), 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_h_period", int'(h_period), 0);
    @(posedge clk); #1;
    w_rst_n = 1'b1;
    applyStimulus(12, H_TOT, 1'b1);
    send_lines(0, V_TOT - 1);
    checkOutput("no_lock_after_reset", locked, 0);
    snapshot();
    applyStimulus(0, H_TOT, 1'b0);
    checkOutput("relock_after_reset", locked, 1);
    send_lines(1, V_TOT - 1);
    check_clean_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the 800x600 60 Hz SVGA timing generator.
- Samples incoming active-low hsync/vsync on the pixel clock, measures line and frame periods, and locks to the expected timing.
- Regenerates pos_x/pos_y/active for downstream capture and pixel-processing logic.
- Sits at the video-input edge of the design, one instance per incoming video stream.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
H_TOTAL, 1056, expected clocks between hsync falling edges
V_TOTAL, 628, expected lines between vsync falling edges
H_OFS, 216, clocks from detected hsync fall to first active pixel
V_OFS, 27, lines from first line after vsync fall to first active line
LOCK_LINES, 4, consecutive correct line periods required before lock
CW, 11, counter / coordinate width

Ports:
clk  in  1  pixel clock
w_rst_n  in  1  synchronous active-low reset
hsync_in  in  1  incoming horizontal sync, active low
vsync_in  in  1  incoming vertical sync, active low
pos_x  out  CW  active pixel column, 0 when not active
pos_y  out  CW  active line, 0 when not active
active  out  1  high on active pixels while locked
frame_start  out  1  one-cycle pulse on pixel (0,0) while locked
locked  out  1  timing lock status
h_period  out  CW  last measured line period (clocks)

Behaviour:
- Reset: clk and w_rst_n only; reset is synchronous and active-low. w_rst_n=0 at a clk edge forces:
  - synchronizer stages to 1
  - hcnt, vcnt, line_cnt, match_cnt to 0
  - FSM to SEARCH
  - all outputs to 0
- Input stage: 2-flop synchronizer per sync input plus a delay flop. hs_fall/vs_fall = previous 1 and current 0. Edge visible 3 clocks after the pin edge.
- hcnt: 0 on the cycle after hs_fall, otherwise +1, saturating at 2^CW-1.
- h_period: registered from hcnt+1 at each hs_fall.
- line_cnt: +1 per hs_fall, cleared on vs_fall; saturates.
- vcnt:
  - vs_fall sets pend_v.
  - The next hs_fall clears vcnt to 0 and clears pend_v.
  - Otherwise each hs_fall increments vcnt, saturating.
  - hs_fall and vs_fall in the same cycle: line_cnt clears, and vcnt clears on that same hs_fall.
- FSM:
  - SEARCH: first hs_fall -> TRACK, match_cnt=0.
  - TRACK:
    - Each hs_fall: match_cnt+1 if hcnt+1==H_TOTAL, else match_cnt=0.
    - vs_fall with match_cnt>=LOCK_LINES -> LOCKED.
    - hcnt reaching 2*H_TOTAL (no hsync) -> SEARCH.
  - LOCKED -> SEARCH on any of:
    - hs_fall with hcnt+1 != H_TOTAL
    - vs_fall with line_cnt != V_TOTAL
    - hcnt reaching 2*H_TOTAL
  - Any exit from LOCKED deasserts locked next cycle.
- Outputs (registered, 1 clock after the counters):
  - active = locked & H_OFS<=hcnt<H_OFS+H_ACTIVE & V_OFS<=vcnt<V_OFS+V_ACTIVE
  - pos_x = hcnt-H_OFS and pos_y = vcnt-V_OFS when active, else 0
  - frame_start = active & pos_x==0 & pos_y==0
- Lock on vs_fall: vertical alignment is valid from the next hs_fall, so the first frame after lock is complete.
- Jitter: none tolerated; periods must match exactly.

Decomposition:
- Shared package: SVGA timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, sync/porch widths) used by both generator and receiver, plus FSM state encoding (SEARCH=0, TRACK=1, LOCKED=2).
- One sub-module: sync_edge_det (2-flop synchronizer + falling-edge pulse), instantiated twice.

Test Plan:
- Clean SVGA stream from the generator, reset released → locked=1 after LOCK_LINES lines plus the next vsync fall; first frame_start at pos_x=0/pos_y=0; exactly 800x600 active cycles per frame.
- Steady state → h_period=1056 every line; active pixels per line=800; pos_x rises 0..799 with no gaps.
- One line shortened to 1000 clocks while locked → locked=0 within 1 clock after the edge is detected; relock after 4 good lines + vsync.
- Frame of 627 lines while locked → locked=0 on the vs_fall; active=0 thereafter until relock.
- hsync held high for >2112 clocks → FSM returns to SEARCH; locked=0; pos_x/pos_y=0.
- w_rst_n=0 mid-frame while locked → all outputs 0 on the next edge; relock proceeds from SEARCH once reset is released.
